// File: rtl/next_pc_predictor.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_predictor
// Description : Single-cycle next-PC predictor for RV32 fetch.
//               - Decodes JAL / JALR / conditional BRANCH from in_instr[6:0]
//                 and computes the redirect target.
//               - Predicts BRANCH direction from a table of BHT_DEPTH 2-bit
//                 saturating counters, indexed by in_pc[IDX+1:2].
//               - Results are registered.
//               - hold freezes the output registers.
//               - BHT updates from branch resolution are never stalled.
// Parameters  : XLEN      - PC/target width (>= 32)
//               BHT_DEPTH - number of counters (power of 2, 4..1024)
//               CNT_RESET - reset value of every counter
// Ports       : clk, rst_n (async, active-low)
//               in_valid, in_instr, in_pc, in_rs1, hold   - lookup side
//               upd_valid, upd_pc, upd_taken              - update side
//               out_valid, out_target, out_taken, out_kind - registered result
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_predictor #(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] CNT_RESET = 2'b01
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic            hold,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    output logic            out_valid,
    output logic [XLEN-1:0] out_target,
    output logic            out_taken,
    output logic [1:0]      out_kind
);

    localparam int         c_IDX       = $clog2(BHT_DEPTH);
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [1:0] c_KIND_NONE = 2'b00;
    localparam logic [1:0] c_KIND_JAL  = 2'b01;
    localparam logic [1:0] c_KIND_JALR = 2'b10;
    localparam logic [1:0] c_KIND_BR   = 2'b11;

    // ------------------------------------------------------------------
    // Immediate extraction (RISC-V J/B/I formats, sign-extended to XLEN)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_i;

    assign w_imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
    assign w_imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_rel_j;
    logic [XLEN-1:0] w_pc_rel_b;
    logic [XLEN-1:0] w_jalr_sum;

    // All sums wrap modulo 2^XLEN; no carry-out is kept.
    assign w_pc_plus4 = in_pc + XLEN'(4);
    assign w_pc_rel_j = in_pc + w_imm_j;
    assign w_pc_rel_b = in_pc + w_imm_b;
    assign w_jalr_sum = in_rs1 + w_imm_i;

    // ------------------------------------------------------------------
    // Branch history table
    // ------------------------------------------------------------------
    logic [1:0]       w_bht [BHT_DEPTH];
    logic [c_IDX-1:0] w_lookup_idx;
    logic [c_IDX-1:0] w_upd_idx;
    logic [1:0]       w_lookup_cnt;

    // PC bits [1:0] never take part in indexing; upper bits alias freely.
    assign w_lookup_idx = in_pc[c_IDX+1:2];
    assign w_upd_idx    = upd_pc[c_IDX+1:2];
    assign w_lookup_cnt = w_bht[w_lookup_idx];

    logic w_unused_upd_pc;
    assign w_unused_upd_pc = ^{upd_pc[XLEN-1:c_IDX+2], upd_pc[1:0]};

    // One saturating counter per entry. The lookup reads the current
    // register value, so a same-cycle update to the same entry is seen by
    // the lookup only on the following cycle (read-before-write).
    for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
        localparam logic [c_IDX-1:0] c_ENTRY = c_IDX'(gi);
        logic [1:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= CNT_RESET;
            end else if (upd_valid && (w_upd_idx == c_ENTRY)) begin
                if (upd_taken) begin
                    if (r_cnt != 2'b11) begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end else if (r_cnt != 2'b00) begin
                    r_cnt <= r_cnt - 2'd1;
                end
            end
        end

        assign w_bht[gi] = r_cnt;
    end

    // ------------------------------------------------------------------
    // Decode and prediction
    // ------------------------------------------------------------------
    logic [1:0]      w_kind;
    logic            w_taken;
    logic [XLEN-1:0] w_target;

    always_comb begin
        w_kind   = c_KIND_NONE;
        w_taken  = 1'b0;
        w_target = w_pc_plus4;
        case (in_instr[6:0])
            c_OP_JAL: begin
                w_kind   = c_KIND_JAL;
                w_taken  = 1'b1;
                w_target = w_pc_rel_j;
            end
            c_OP_JALR: begin
                w_kind   = c_KIND_JALR;
                w_taken  = 1'b1;
                w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
            end
            c_OP_BRANCH: begin
                w_kind  = c_KIND_BR;
                w_taken = w_lookup_cnt[1];
                // A not-taken branch falls through to pc + 4.
                if (w_lookup_cnt[1]) begin
                    w_target = w_pc_rel_b;
                end
            end
            default: begin
                w_kind   = c_KIND_NONE;
                w_taken  = 1'b0;
                w_target = w_pc_plus4;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_target;
    logic            r_out_taken;
    logic [1:0]      r_out_kind;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_target <= '0;
            r_out_taken  <= 1'b0;
            r_out_kind   <= c_KIND_NONE;
        end else if (!hold) begin
            r_out_valid  <= in_valid;
            r_out_target <= w_target;
            r_out_taken  <= w_taken;
            r_out_kind   <= w_kind;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_target = r_out_target;
    assign out_taken  = r_out_taken;
    assign out_kind   = r_out_kind;

endmodule
`default_nettype wire

// File: tb/tb_next_pc_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_next_pc_predictor
// Description : Directed self-checking bench for next_pc_predictor with
//               hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_next_pc_predictor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1;
    logic        hold;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        out_valid;
    logic [31:0] out_target;
    logic        out_taken;
    logic [1:0]  out_kind;

    int vectors    = 0;
    int miscompares = 0;

    next_pc_predictor #(
        .XLEN      (32),
        .BHT_DEPTH (64),
        .CNT_RESET (2'b01)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_rs1     (in_rs1),
        .hold       (hold),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .out_valid  (out_valid),
        .out_target (out_target),
        .out_taken  (out_taken),
        .out_kind   (out_kind)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [31:0] c_JAL8   = 32'h0080_006F;
    localparam logic [31:0] c_BEQM4  = 32'hFE00_0EE3;
    localparam logic [31:0] c_JALR4  = 32'h0040_8067;
    localparam logic [31:0] c_NOP    = 32'h0000_0013;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge; sampling happens 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [31:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] tgt,
                             input logic tk, input logic [1:0] kd);
        check({tag, ".valid"},  {31'd0, out_valid}, {31'd0, v});
        check({tag, ".target"}, out_target, tgt);
        check({tag, ".taken"},  {31'd0, out_taken}, {31'd0, tk});
        check({tag, ".kind"},   {30'd0, out_kind}, {30'd0, kd});
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = c_NOP;
        in_pc     = 32'h0;
        in_rs1    = 32'h0;
        hold      = 1'b0;
        upd_valid = 1'b0;
        upd_pc    = 32'h0;
        upd_taken = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        #10;
        check_out("reset", 1'b0, 32'h0, 1'b0, 2'b00);
        rst_n = 1'b1;
        step();

        // JAL +8 from 0x1000
        lookup(32'h0000_1000, c_JAL8);
        step();
        check_out("jal", 1'b1, 32'h0000_1008, 1'b1, 2'b01);

        // Backward branch, counter at reset value 01 -> not taken
        lookup(32'h0000_2000, c_BEQM4);
        step();
        check_out("br_reset", 1'b1, 32'h0000_2004, 1'b0, 2'b11);

        // Train index 0 with two taken updates: 01 -> 10 -> 11
        in_valid  = 1'b0;
        in_instr  = c_NOP;
        upd_valid = 1'b1;
        upd_pc    = 32'h0000_2000;
        upd_taken = 1'b1;
        step();
        step();
        upd_valid = 1'b0;
        lookup(32'h0000_2000, c_BEQM4);
        step();
        check_out("br_trained", 1'b1, 32'h0000_1FFC, 1'b1, 2'b11);

        // Three more taken updates must saturate at 11; one decrement then
        // leaves 10 (still taken), a second leaves 01 (not taken).
        in_valid  = 1'b0;
        upd_valid = 1'b1;
        upd_taken = 1'b1;
        step();
        step();
        step();
        upd_taken = 1'b0;
        step();
        upd_valid = 1'b0;
        lookup(32'h0000_2000, c_BEQM4);
        step();
        check("sat_hi.taken", {31'd0, out_taken}, 32'd1);
        check("sat_hi.target", out_target, 32'h0000_1FFC);
        upd_valid = 1'b1;
        upd_taken = 1'b0;
        step();
        upd_valid = 1'b0;
        step();
        check("dec_01.taken", {31'd0, out_taken}, 32'd0);
        check("dec_01.target", out_target, 32'h0000_2004);

        // JALR 4(x1), rs1 = 0x3003 -> 0x3006
        lookup(32'h0000_4000, c_JALR4);
        in_rs1 = 32'h0000_3003;
        step();
        check_out("jalr", 1'b1, 32'h0000_3006, 1'b1, 2'b10);

        // Same-cycle update and lookup at index 4 (counter 01): read-before-write
        lookup(32'h0000_2010, c_BEQM4);
        upd_valid = 1'b1;
        upd_pc    = 32'h0000_2010;
        upd_taken = 1'b1;
        step();
        check_out("collide", 1'b1, 32'h0000_2014, 1'b0, 2'b11);
        upd_valid = 1'b0;
        step();
        check_out("after_collide", 1'b1, 32'h0000_200C, 1'b1, 2'b11);

        // Hold for 3 cycles: outputs frozen, lookup inputs ignored, while
        // two taken updates to index 0 still land (01 -> 10 -> 11).
        hold      = 1'b1;
        lookup(32'h0000_1000, c_JAL8);
        in_valid  = 1'b0;
        upd_valid = 1'b1;
        upd_pc    = 32'h0000_2000;
        upd_taken = 1'b1;
        step();
        check_out("hold1", 1'b1, 32'h0000_200C, 1'b1, 2'b11);
        step();
        check_out("hold2", 1'b1, 32'h0000_200C, 1'b1, 2'b11);
        upd_valid = 1'b0;
        step();
        check_out("hold3", 1'b1, 32'h0000_200C, 1'b1, 2'b11);
        hold = 1'b0;
        lookup(32'h0000_2000, c_BEQM4);
        step();
        check_out("upd_in_hold", 1'b1, 32'h0000_1FFC, 1'b1, 2'b11);

        // Low PC bits ignored for indexing: 0x2003 maps to index 0 (counter 11)
        lookup(32'h0000_2003, c_BEQM4);
        step();
        check("lowbits.taken", {31'd0, out_taken}, 32'd1);
        check("lowbits.target", out_target, 32'h0000_1FFF);

        // PC + 4 wraps to zero without complaint
        lookup(32'hFFFF_FFFC, c_NOP);
        step();
        check_out("wrap", 1'b1, 32'h0000_0000, 1'b0, 2'b00);

        // Asynchronous reset mid-cycle, with an update in flight
        upd_valid = 1'b1;
        upd_pc    = 32'h0000_2010;
        upd_taken = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 32'h0, 1'b0, 2'b00);
        upd_valid = 1'b0;
        in_valid  = 1'b0;
        step();
        #2 rst_n = 1'b1;

        // Counters are back at 01 and the first lookup appears one edge later
        lookup(32'h0000_2000, c_BEQM4);
        step();
        check_out("post_rst0", 1'b1, 32'h0000_2004, 1'b0, 2'b11);
        lookup(32'h0000_2010, c_BEQM4);
        step();
        check_out("post_rst4", 1'b1, 32'h0000_2014, 1'b0, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/next_pc_predictor.md
NEXT_PC_PREDICTOR -- requirements
Module: next_pc_predictor

Interface
REQ-001 Parameter XLEN, default 32: PC and target width; SHALL be at least 32.
REQ-002 Parameter BHT_DEPTH, default 64: number of 2-bit counters; SHALL be a power of 2, range 4 to 1024.
REQ-003 Parameter CNT_RESET, default 2'b01: reset value of every counter (weakly not-taken).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  lookup request.
REQ-007 in_instr  input  32  RV32 instruction word.
REQ-008 in_pc  input  XLEN  address of in_instr.
REQ-009 in_rs1  input  XLEN  rs1 operand, used for JALR only.
REQ-010 hold  input  1  stall; output registers keep their values.
REQ-011 upd_valid  input  1  branch-resolution update strobe.
REQ-012 upd_pc  input  XLEN  PC of the resolved conditional branch.
REQ-013 upd_taken  input  1  actual branch outcome.
REQ-014 out_valid  output  1  registered lookup result valid.
REQ-015 out_target  output  XLEN  predicted next PC.
REQ-016 out_taken  output  1  predicted redirect.
REQ-017 out_kind  output  2  00 = not control flow, 01 = JAL, 10 = JALR, 11 = BRANCH.

Function
REQ-018 Decode in_instr[6:0] as follows: 1101111 gives JAL, 1100111 gives JALR, 1100011 gives BRANCH, any other value gives kind 00.
REQ-019 JAL immediate SHALL be sign-extended {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} (21 bits, shift by 1, not 2).
REQ-020 BRANCH immediate SHALL be sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} (13 bits).
REQ-021 JALR immediate SHALL be sign-extended instr[31:20].
REQ-022 Targets:
- JAL and BRANCH: in_pc + imm.
- JALR: (in_rs1 + imm) with bit 0 forced to 0.
- Kind 00: in_pc + 4.
- All sums modulo 2^XLEN; wrap-around SHALL NOT be flagged.
REQ-023 Prediction:
- JAL and JALR: taken = 1.
- BRANCH: taken = MSB of counter BHT[in_pc[IDX+1:2]], where IDX = log2(BHT_DEPTH).
- Kind 00: taken = 0.
REQ-024 out_target SHALL equal in_pc + 4 whenever out_taken = 0, including a BRANCH predicted not-taken.
REQ-025 Latency SHALL be exactly 1 cycle: when hold = 0, out_* registers load the decode of in_* and out_valid <= in_valid.
REQ-026 When hold = 1, every out_* register SHALL keep its value, and the lookup inputs are ignored.
REQ-027 Update: when upd_valid = 1, counter BHT[upd_pc[IDX+1:2]] SHALL saturate-increment if upd_taken = 1, otherwise saturate-decrement.
REQ-028 Counters SHALL saturate at 00 and 11.
REQ-029 Updates SHALL proceed regardless of hold.
REQ-030 When an update and a lookup hit the same index in the same cycle, the lookup SHALL use the pre-update counter value (read-before-write).
REQ-031 Consecutive updates to one index SHALL accumulate cycle by cycle, with no lost update.
REQ-032 in_pc and upd_pc bits [1:0] SHALL be ignored for indexing.
REQ-033 Index aliasing on PC bits above IDX+1 is permitted and SHALL NOT be detected.

Reset
REQ-034 While rst_n = 0, outputs SHALL read: out_valid = 0, out_target = 0, out_taken = 0, out_kind = 00.
REQ-035 While rst_n = 0, every BHT counter SHALL read CNT_RESET.
REQ-036 Reset assertion mid-operation SHALL clear the outputs immediately, without waiting for clk, and SHALL discard any in-flight update.
REQ-037 The first lookup accepted after rst_n rises SHALL produce a result on the following edge.

Verification
REQ-038 JAL test: in_pc = 0x0000_1000, instr = 0x0080_006F (jal x0, +8) -> next cycle out_target = 0x0000_1008, out_taken = 1, out_kind = 01.
REQ-039 Backward branch test: in_pc = 0x0000_2000, instr = 0xFE00_0EE3 (beq x0, x0, -4), counter at reset (01) -> out_taken = 0, out_target = 0x0000_2004.
REQ-040 Counter training test:
- Apply two upd_taken = 1 updates at upd_pc = 0x2000, then repeat the REQ-039 lookup.
- Required: out_taken = 1, out_target = 0x0000_1FFC.
- Apply three further taken updates; the counter SHALL stay at 11.
REQ-041 JALR test: in_rs1 = 0x0000_3003, instr = 0x0040_8067 (jalr x0, 4(x1)) -> out_target = 0x0000_3006 (bit 0 cleared), out_kind = 10.
REQ-042 Collision and stall test:
- Same-cycle update (taken, counter 01) and lookup at the same index -> lookup predicts not-taken; the next lookup predicts taken.
- hold = 1 for 3 cycles -> outputs stay constant.
REQ-043 Wrap and reset test:
- in_pc = 0xFFFF_FFFC, non-control instruction -> out_target = 0x0000_0000.
- Assert rst_n = 0 between edges -> out_valid = 0 immediately.
